// File: rtl/cbus_sram_target_pkg.sv
// CBus request/response types, burst encodings and target FSM states shared by the
// cbus_sram_target slice.
package cbus_sram_target_pkg;

  typedef logic [2:0] msize_t;
  typedef logic [3:0] mlen_t;

  typedef enum logic [1:0] {
    AXI_BURST_FIXED = 2'b00,
    AXI_BURST_INCR  = 2'b01,
    AXI_BURST_WRAP  = 2'b10
  } axi_burst_type_t;

  localparam int CBUS_AW = 32;
  localparam int CBUS_DW = 64;
  localparam int CBUS_SW = CBUS_DW / 8;

  typedef struct packed {
    logic                 valid;
    logic                 is_write;
    msize_t               size;
    logic [CBUS_AW-1:0]   addr;
    logic [CBUS_SW-1:0]   strobe;
    logic [CBUS_DW-1:0]   data;
    mlen_t                len;
    axi_burst_type_t      burst;
  } cbus_req_t;

  typedef struct packed {
    logic               ready;
    logic               last;
    logic [CBUS_DW-1:0] data;
  } cbus_resp_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_BEAT
  } tgt_state_t;

  // Wrapping bursts need a power-of-two beat count; anything else degrades to INCR.
  function automatic logic wrap_len_ok(mlen_t len);
    return (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
  endfunction

endpackage

// File: rtl/cbus_sram_target_if.sv
// CBus request/response bundle with initiator (master) and responder (slave) views.
interface cbus_sram_target_if;
  import cbus_sram_target_pkg::*;

  cbus_req_t  req;
  cbus_resp_t resp;

  modport master (output req, input resp);
  modport slave  (input req, output resp);

endinterface

// File: rtl/cbus_burst_addr_gen.sv
// Next word index for a CBus burst: pure function of current index, len and burst type.
module cbus_burst_addr_gen
  import cbus_sram_target_pkg::*;
#(
  parameter int IDX_W = 10
) (
  input  logic [IDX_W-1:0] cur_idx_i,
  input  mlen_t            len_i,
  input  axi_burst_type_t  burst_i,
  output logic [IDX_W-1:0] nxt_idx_o
);

  logic [IDX_W-1:0] incr_idx;
  logic [IDX_W-1:0] wrap_mask;
  logic [IDX_W-1:0] wrap_idx;

  always_comb begin
    incr_idx  = cur_idx_i + IDX_W'(1);
    // len+1 is a power of two for legal WRAP, so len itself is the low-bit mask.
    wrap_mask = IDX_W'(len_i);
    wrap_idx  = (cur_idx_i & ~wrap_mask) | (incr_idx & wrap_mask);
    nxt_idx_o = incr_idx;
    case (burst_i)
      AXI_BURST_FIXED: nxt_idx_o = cur_idx_i;
      AXI_BURST_WRAP:  nxt_idx_o = wrap_len_ok(len_i) ? wrap_idx : incr_idx;
      default:         nxt_idx_o = incr_idx;
    endcase
  end

endmodule

// File: rtl/cbus_sram_target.sv
// Word-addressed CBus memory target: FIXED/INCR/WRAP bursts with programmable first-beat
// latency. Define CBUS_TARGET_CHECK_EN to enable the sticky request-stability checker.
module cbus_sram_target
  import cbus_sram_target_pkg::*;
#(
  parameter int    NUM_WORDS = 1024,
  parameter int    LATENCY   = 1,
  parameter string INIT_FILE = ""
) (
  input  logic                clk,
  input  logic                reset,
  cbus_sram_target_if.slave   bus,
  output logic                proto_err
);

  localparam int IW = $clog2(NUM_WORDS);

  logic [CBUS_DW-1:0] mem [NUM_WORDS];

  tgt_state_t       state_q;
  logic [IW-1:0]    idx_q;
  logic [IW-1:0]    nxt_idx;
  logic [IW-1:0]    req_idx;
  mlen_t            beat_q;
  mlen_t            len_q;
  logic [3:0]       lat_q;
  axi_burst_type_t  burst_q;
  logic             wr_q;
  logic             ready_q;
  logic             last_q;
  logic [CBUS_DW-1:0] rdata;

  assign req_idx = bus.req.addr[IW+2:3];

  cbus_burst_addr_gen #(
    .IDX_W (IW)
  ) u_addr_gen (
    .cur_idx_i (idx_q),
    .len_i     (len_q),
    .burst_i   (burst_q),
    .nxt_idx_o (nxt_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b0;
      last_q  <= 1'b0;
      beat_q  <= '0;
      lat_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.req.valid) begin
            idx_q   <= req_idx;
            len_q   <= bus.req.len;
            burst_q <= bus.req.burst;
            wr_q    <= bus.req.is_write;
            beat_q  <= '0;
            lat_q   <= 4'(LATENCY);
            if (LATENCY == 0) begin
              state_q <= ST_BEAT;
              ready_q <= 1'b1;
              last_q  <= (bus.req.len == 4'd0);
            end else begin
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          lat_q <= lat_q - 4'd1;
          if (lat_q == 4'd1) begin
            state_q <= ST_BEAT;
            ready_q <= 1'b1;
            last_q  <= (len_q == 4'd0);
          end
        end
        ST_BEAT: begin
          if (last_q) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b0;
            last_q  <= 1'b0;
          end else begin
            beat_q <= beat_q + 4'd1;
            idx_q  <= nxt_idx;
            last_q <= (mlen_t'(beat_q + 4'd1) == len_q);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b0;
          last_q  <= 1'b0;
        end
      endcase
    end
  end

  // A write beat coinciding with reset is dropped, not committed.
  always_ff @(posedge clk) begin
    if (!reset && ready_q && wr_q) begin
      for (int b = 0; b < CBUS_SW; b++) begin
        if (bus.req.strobe[b]) mem[idx_q][8*b +: 8] <= bus.req.data[8*b +: 8];
      end
    end
  end

  assign rdata    = (ready_q && !wr_q) ? mem[idx_q] : '0;
  assign bus.resp = {ready_q, last_q, rdata};

`ifdef CBUS_TARGET_CHECK_EN
  logic [CBUS_AW-1:0] addr_q;
  logic               err_q;
  logic [31:0]        cyc_q;
  logic               mismatch;

  assign mismatch = (state_q != ST_IDLE) &&
                    (!bus.req.valid || (bus.req.addr != addr_q) || (bus.req.len != len_q) ||
                     (bus.req.burst != burst_q) || (bus.req.is_write != wr_q));

  always_ff @(posedge clk) begin
    cyc_q <= cyc_q + 32'd1;
    if (state_q == ST_IDLE && bus.req.valid) addr_q <= bus.req.addr;
    if (reset) begin
      err_q <= 1'b0;
    end else if (mismatch) begin
      err_q <= 1'b1;
      $error("cbus_sram_target: request changed mid-transaction at cycle %0d", cyc_q);
    end
  end

  assign proto_err = err_q;
`else
  assign proto_err = 1'b0;
`endif

  logic unused_req_bits;
  assign unused_req_bits = &{1'b0, bus.req.size, bus.req.addr[CBUS_AW-1:IW+3], bus.req.addr[2:0]};

endmodule

// File: tb/tb_cbus_sram_target.sv
// Directed bench for cbus_sram_target: latency, INCR/WRAP/FIXED, strobes, wrap-around,
// aliasing, reset abort and request-stability flag.
module tb_cbus_sram_target;
  import cbus_sram_target_pkg::*;

  localparam int NW  = 1024;
  localparam int LAT = 1;
`ifdef CBUS_TARGET_CHECK_EN
  localparam logic [63:0] PERR_EXP = 64'd1;
`else
  localparam logic [63:0] PERR_EXP = 64'd0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic proto_err;

  cbus_sram_target_if bus ();

  cbus_sram_target #(
    .NUM_WORDS (NW),
    .LATENCY   (LAT),
    .INIT_FILE ("")
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .proto_err (proto_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [63:0] wdat [16];
  logic [63:0] rexp [16];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic xfer(input string tag, input bit wr, input logic [31:0] addr, input mlen_t len,
                      input axi_burst_type_t burst, input logic [7:0] strb,
                      input int abort_beat, input bit bump);
    int  k;
    int  cyc;
    bit  done;
    bit  aborted;
    @(posedge clk); #1;
    bus.req.valid    = 1'b1;
    bus.req.is_write = wr;
    bus.req.size     = 3'd3;
    bus.req.addr     = addr;
    bus.req.strobe   = strb;
    bus.req.data     = wdat[0];
    bus.req.len      = len;
    bus.req.burst    = burst;
    @(negedge clk);
    check({tag, "_acc_rdy"}, 64'(bus.resp.ready), 64'd0);
    k = 0; cyc = 0; done = 1'b0; aborted = 1'b0;
    while (!done) begin
      @(posedge clk); #1;
      cyc++;
      if (bump && cyc == 1) bus.req.addr = addr ^ 32'h8;
      bus.req.data = wdat[k];
      @(negedge clk);
      if (bus.resp.ready) begin
        if (k == 0) check({tag, "_lat"}, 64'(cyc), 64'(LAT + 1));
        if (bump && k == 0) check({tag, "_perr"}, 64'(proto_err), PERR_EXP);
        check({tag, "_last"}, 64'(bus.resp.last), 64'(k == int'(len)));
        check({tag, "_data"}, bus.resp.data, wr ? 64'd0 : rexp[k]);
        if (k == abort_beat) begin
          reset = 1'b1;
          @(posedge clk); #1;
          reset = 1'b0;
          bus.req = '0;
          @(negedge clk);
          check({tag, "_rst_rdy"}, 64'(bus.resp.ready), 64'd0);
          check({tag, "_rst_data"}, bus.resp.data, 64'd0);
          aborted = 1'b1;
          done = 1'b1;
        end else if (k == int'(len)) begin
          done = 1'b1;
        end
        k++;
      end else if (k > 0) begin
        check({tag, "_gap_rdy"}, 64'(bus.resp.ready), 64'd1);
        done = 1'b1;
      end
      if (!done && cyc > 40) begin
        check({tag, "_timeout"}, 64'(cyc), 64'd0);
        done = 1'b1;
      end
    end
    if (!aborted) begin
      check({tag, "_nbeats"}, 64'(k), 64'(int'(len) + 1));
      @(posedge clk); #1;
      bus.req = '0;
      @(negedge clk);
      check({tag, "_post_rdy"}, 64'(bus.resp.ready), 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset   = 1'b1;
    bus.req = '0;
    for (int i = 0; i < 16; i++) begin
      wdat[i] = '0;
      rexp[i] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 64'(bus.resp.ready), 64'd0);
    check("rst_last", 64'(bus.resp.last), 64'd0);
    check("rst_data", bus.resp.data, 64'd0);
    check("rst_perr", 64'(proto_err), 64'd0);
    reset = 1'b0;

    // Single-beat write then read of word 4.
    wdat[0] = 64'h1122334455667788;
    xfer("t1w", 1'b1, 32'h20, 4'd0, AXI_BURST_INCR, 8'hFF, -1, 1'b0);
    rexp[0] = 64'h1122334455667788;
    xfer("t1r", 1'b0, 32'h20, 4'd0, AXI_BURST_INCR, 8'hFF, -1, 1'b0);

    // Four-beat INCR write/read at words 8..11.
    for (int i = 0; i < 4; i++) begin
      wdat[i] = 64'hA0 + 64'(i);
      rexp[i] = 64'hA0 + 64'(i);
    end
    xfer("t2w", 1'b1, 32'h40, 4'd3, AXI_BURST_INCR, 8'hFF, -1, 1'b0);
    xfer("t2r", 1'b0, 32'h40, 4'd3, AXI_BURST_INCR, 8'hFF, -1, 1'b0);

    // WRAP from word 10: 10, 11, 8, 9.
    rexp[0] = 64'hA2; rexp[1] = 64'hA3; rexp[2] = 64'hA0; rexp[3] = 64'hA1;
    xfer("t3wrap", 1'b0, 32'h50, 4'd3, AXI_BURST_WRAP, 8'hFF, -1, 1'b0);
    // FIXED from word 10.
    for (int i = 0; i < 4; i++) rexp[i] = 64'hA2;
    xfer("t3fix", 1'b0, 32'h50, 4'd3, AXI_BURST_FIXED, 8'hFF, -1, 1'b0);

    // Byte strobes merge into the existing word.
    wdat[0] = 64'h1111111111111111;
    xfer("t4init", 1'b1, 32'hA0, 4'd0, AXI_BURST_INCR, 8'hFF, -1, 1'b0);
    wdat[0] = 64'hFFFFFFFF_DEADBEEF;
    xfer("t4part", 1'b1, 32'hA0, 4'd0, AXI_BURST_INCR, 8'h0F, -1, 1'b0);
    rexp[0] = 64'h11111111_DEADBEEF;
    xfer("t4rd", 1'b0, 32'hA0, 4'd0, AXI_BURST_INCR, 8'hFF, -1, 1'b0);

    // INCR across the top of memory: 1022, 1023, 0, 1.
    for (int i = 0; i < 4; i++) wdat[i] = 64'hB0 + 64'(i);
    xfer("t5w", 1'b1, 32'h1FF0, 4'd3, AXI_BURST_INCR, 8'hFF, -1, 1'b0);
    rexp[0] = 64'hB2; rexp[1] = 64'hB3;
    xfer("t5r01", 1'b0, 32'h0, 4'd1, AXI_BURST_INCR, 8'hFF, -1, 1'b0);
    rexp[0] = 64'hB1;
    xfer("t5alias", 1'b0, 32'h3FF8, 4'd0, AXI_BURST_INCR, 8'hFF, -1, 1'b0);

    // Reset on beat 2 (word 0) of a write burst.
    for (int i = 0; i < 4; i++) wdat[i] = 64'hE0 + 64'(i);
    xfer("t5abort", 1'b1, 32'h1FF0, 4'd3, AXI_BURST_INCR, 8'hFF, 2, 1'b0);
    rexp[0] = 64'hB2;
    xfer("t5idx0", 1'b0, 32'h0, 4'd0, AXI_BURST_INCR, 8'hFF, -1, 1'b0);
    rexp[0] = 64'hE0; rexp[1] = 64'hE1;
    xfer("t5after", 1'b0, 32'h1FF0, 4'd1, AXI_BURST_INCR, 8'hFF, -1, 1'b0);

    // Address changed during WAIT: burst completes, flag reflects checker build.
    rexp[0] = 64'hA0; rexp[1] = 64'hA1;
    xfer("t6", 1'b0, 32'h40, 4'd1, AXI_BURST_INCR, 8'hFF, -1, 1'b1);
    check("t6_perr_sticky", 64'(proto_err), PERR_EXP);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("t6_perr_clr", 64'(proto_err), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
